// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, 8 data bits MSB-first, optional parity, 1 or 2 stop bits.
// A one-entry holding buffer lets the next byte queue while the current frame shifts out.
module uart_transmitter #(
  parameter int BAUD_RATE      = 9600,
  parameter int CLOCK_FREQ     = 50000000,
  parameter int CYCLES_PER_BIT = CLOCK_FREQ / BAUD_RATE,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       enable,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       Tx,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY_BIT = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [15:0] BIT_LAST  = 16'(CYCLES_PER_BIT - 1);
  localparam logic        STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;
  localparam logic        ODD_PAR   = (PARITY == 2) ? 1'b1 : 1'b0;

  function automatic logic parity_of(input logic [7:0] d);
    return (^d) ^ ODD_PAR;
  endfunction

  state_t      state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic        stop_cnt;
  logic [7:0]  shifter;
  logic        par_bit;
  logic [7:0]  buf_data;
  logic        buf_full;
  logic        bit_end;
  logic        accept;
  logic        load;

  assign tx_ready = ~buf_full & enable;
  assign accept   = tx_valid & tx_ready;
  assign bit_end  = (baud_cnt == BIT_LAST);

  // Shifter loads from the buffer when idle, or straight out of the last stop bit.
  always_comb begin
    load = 1'b0;
    if (enable && buf_full) begin
      if (state == IDLE) begin
        load = 1'b1;
      end else if (state == STOP && bit_end && stop_cnt == STOP_LAST) begin
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
    end else begin
      load = 1'b0;
    end
  end

  // Holding buffer.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      buf_full <= 1'b0;
      buf_data <= 8'h00;
    end else if (!enable) begin
      buf_full <= 1'b0;
    end else if (accept) begin
      buf_data <= tx_data;
      buf_full <= 1'b1;
    end else if (load) begin
      buf_full <= 1'b0;
    end
  end

  // Frame sequencer with registered line and busy outputs.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state    <= IDLE;
      Tx       <= 1'b1;
      busy     <= 1'b0;
      baud_cnt <= 16'd0;
      bit_idx  <= 3'd0;
      stop_cnt <= 1'b0;
      shifter  <= 8'h00;
      par_bit  <= 1'b0;
    end else if (!enable) begin
      state    <= IDLE;
      Tx       <= 1'b1;
      busy     <= 1'b0;
      baud_cnt <= 16'd0;
      bit_idx  <= 3'd0;
      stop_cnt <= 1'b0;
    end else if (load) begin
      shifter  <= buf_data;
      par_bit  <= parity_of(buf_data);
      state    <= START;
      Tx       <= 1'b0;
      busy     <= 1'b1;
      baud_cnt <= 16'd0;
      bit_idx  <= 3'd0;
      stop_cnt <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          Tx       <= 1'b1;
          busy     <= 1'b0;
          baud_cnt <= 16'd0;
        end
        START: begin
          if (bit_end) begin
            state    <= DATA;
            bit_idx  <= 3'd7;
            Tx       <= shifter[7];
            baud_cnt <= 16'd0;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= 16'd0;
            if (bit_idx == 3'd0) begin
              if (PARITY != 0) begin
                state <= PARITY_BIT;
                Tx    <= par_bit;
              end else begin
                state    <= STOP;
                Tx       <= 1'b1;
                stop_cnt <= 1'b0;
              end
            end else begin
              bit_idx <= bit_idx - 3'd1;
              Tx      <= shifter[bit_idx - 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        PARITY_BIT: begin
          if (bit_end) begin
            state    <= STOP;
            Tx       <= 1'b1;
            stop_cnt <= 1'b0;
            baud_cnt <= 16'd0;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        STOP: begin
          Tx <= 1'b1;
          if (bit_end) begin
            baud_cnt <= 16'd0;
            if (stop_cnt == STOP_LAST) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: begin
          state    <= IDLE;
          Tx       <= 1'b1;
          busy     <= 1'b0;
          baud_cnt <= 16'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter; four instances cover no parity, even, odd and two stop bits.
module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       nRst;
  logic       enable;
  logic [7:0] tx_data;
  logic [3:0] valid;
  logic [3:0] ready;
  logic [3:0] txl;
  logic [3:0] busy;
  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  uart_transmitter #(.BAUD_RATE(1), .CLOCK_FREQ(4), .CYCLES_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .nRst(nRst), .enable(enable), .tx_data(tx_data), .tx_valid(valid[0]),
    .tx_ready(ready[0]), .Tx(txl[0]), .busy(busy[0]));
  uart_transmitter #(.BAUD_RATE(1), .CLOCK_FREQ(4), .CYCLES_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) dut1 (
    .clk(clk), .nRst(nRst), .enable(enable), .tx_data(tx_data), .tx_valid(valid[1]),
    .tx_ready(ready[1]), .Tx(txl[1]), .busy(busy[1]));
  uart_transmitter #(.BAUD_RATE(1), .CLOCK_FREQ(4), .CYCLES_PER_BIT(4), .PARITY(2), .STOP_BITS(1)) dut2 (
    .clk(clk), .nRst(nRst), .enable(enable), .tx_data(tx_data), .tx_valid(valid[2]),
    .tx_ready(ready[2]), .Tx(txl[2]), .busy(busy[2]));
  uart_transmitter #(.BAUD_RATE(1), .CLOCK_FREQ(4), .CYCLES_PER_BIT(4), .PARITY(0), .STOP_BITS(2)) dut3 (
    .clk(clk), .nRst(nRst), .enable(enable), .tx_data(tx_data), .tx_valid(valid[3]),
    .tx_ready(ready[3]), .Tx(txl[3]), .busy(busy[3]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a byte to an idle instance; returns positioned on start-bit cycle 0.
  task automatic send(input int sel, input logic [7:0] d);
    int n;
    n = 0;
    tx_data = d;
    valid[sel] = 1'b1;
    while (ready[sel] !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (ready[sel] !== 1'b1) begin
      fails++;
      $display("FAIL send_ready: dut%0d tx_ready=%b expected 1", sel, ready[sel]);
    end
    tick();
    valid[sel] = 1'b0;
    checks++;
    if (ready[sel] !== 1'b0) begin
      fails++;
      $display("FAIL accept_ready: dut%0d tx_ready=%b expected 0", sel, ready[sel]);
    end
    checks++;
    if (txl[sel] !== 1'b1 || busy[sel] !== 1'b0) begin
      fails++;
      $display("FAIL accept_idle: dut%0d Tx=%b busy=%b expected Tx=1 busy=0", sel, txl[sel], busy[sel]);
    end
    tick();
  endtask

  // Check every cycle of one frame; optionally queue the next byte during it.
  task automatic frame(input int sel, input logic [11:0] exp, input int nbits,
                       input logic nxt, input logic [7:0] nxt_data);
    for (int c = 0; c < nbits * 4; c++) begin
      logic e;
      e = exp[nbits - 1 - c / 4];
      checks++;
      if (txl[sel] !== e) begin
        fails++;
        $display("FAIL frame_tx: dut%0d cycle %0d Tx=%b expected %b", sel, c, txl[sel], e);
      end
      checks++;
      if (busy[sel] !== 1'b1) begin
        fails++;
        $display("FAIL frame_busy: dut%0d cycle %0d busy=%b expected 1", sel, c, busy[sel]);
      end
      if (nxt && c == 0) begin
        tx_data = nxt_data;
        valid[sel] = 1'b1;
      end
      if (nxt && c == 1) begin
        valid[sel] = 1'b0;
        checks++;
        if (ready[sel] !== 1'b0) begin
          fails++;
          $display("FAIL held_ready: dut%0d tx_ready=%b expected 0", sel, ready[sel]);
        end
      end
      if (nxt && c == nbits * 4 - 1) begin
        checks++;
        if (ready[sel] !== 1'b0) begin
          fails++;
          $display("FAIL held_ready_end: dut%0d tx_ready=%b expected 0", sel, ready[sel]);
        end
      end
      tick();
    end
    checks++;
    if (ready[sel] !== 1'b1) begin
      fails++;
      $display("FAIL frame_end_ready: dut%0d tx_ready=%b expected 1", sel, ready[sel]);
    end
    if (nxt) begin
      checks++;
      if (txl[sel] !== 1'b0 || busy[sel] !== 1'b1) begin
        fails++;
        $display("FAIL next_start: dut%0d Tx=%b busy=%b expected Tx=0 busy=1", sel, txl[sel], busy[sel]);
      end
    end else begin
      checks++;
      if (txl[sel] !== 1'b1 || busy[sel] !== 1'b0) begin
        fails++;
        $display("FAIL frame_end: dut%0d Tx=%b busy=%b expected Tx=1 busy=0", sel, txl[sel], busy[sel]);
      end
    end
  endtask

  task automatic test_reset();
    nRst = 1'b0;
    enable = 1'b1;
    valid = 4'b0000;
    tx_data = 8'h00;
    repeat (3) tick();
    nRst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (txl !== 4'hF || busy !== 4'h0 || ready !== 4'hF) begin
        fails++;
        $display("FAIL reset_idle: cycle %0d Tx=%b busy=%b ready=%b expected 1111 0000 1111", i, txl, busy, ready);
      end
      tick();
    end
  endtask

  task automatic test_basic();
    send(0, 8'hA5);
    frame(0, 12'b00_0101001011, 10, 1'b0, 8'h00);
  endtask

  task automatic test_back_to_back();
    send(0, 8'h3C);
    frame(0, 12'b00_0001111001, 10, 1'b1, 8'hC3);
    frame(0, 12'b00_0110000111, 10, 1'b0, 8'h00);
  endtask

  task automatic test_parity();
    send(1, 8'hA5);
    frame(1, 12'b0_01010010101, 11, 1'b0, 8'h00);
    send(2, 8'hA5);
    frame(2, 12'b0_01010010111, 11, 1'b0, 8'h00);
    send(1, 8'h01);
    frame(1, 12'b0_00000000111, 11, 1'b0, 8'h00);
  endtask

  task automatic test_two_stop();
    send(3, 8'h00);
    frame(3, 12'b0_00000000011, 11, 1'b1, 8'h00);
    frame(3, 12'b0_00000000011, 11, 1'b0, 8'h00);
  endtask

  task automatic test_enable_drop();
    send(0, 8'hA5);
    tx_data = 8'h5A;
    valid[0] = 1'b1;
    tick();
    valid[0] = 1'b0;
    checks++;
    if (ready[0] !== 1'b0) begin
      fails++;
      $display("FAIL drop_buffered: tx_ready=%b expected 0", ready[0]);
    end
    repeat (14) tick();
    enable = 1'b0;
    tick();
    checks++;
    if (txl[0] !== 1'b1 || busy[0] !== 1'b0 || ready[0] !== 1'b0) begin
      fails++;
      $display("FAIL drop_abort: Tx=%b busy=%b ready=%b expected 1 0 0", txl[0], busy[0], ready[0]);
    end
    enable = 1'b1;
    #1;
    checks++;
    if (ready[0] !== 1'b1) begin
      fails++;
      $display("FAIL drop_cleared: tx_ready=%b expected 1", ready[0]);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (txl[0] !== 1'b1 || busy[0] !== 1'b0) begin
        fails++;
        $display("FAIL drop_no_resume: cycle %0d Tx=%b busy=%b expected 1 0", i, txl[0], busy[0]);
      end
    end
  endtask

  task automatic test_async_reset();
    send(0, 8'hA5);
    repeat (9) tick();
    checks++;
    if (txl[0] !== 1'b0) begin
      fails++;
      $display("FAIL rst_pre: Tx=%b expected 0", txl[0]);
    end
    #2;
    nRst = 1'b0;
    #1;
    checks++;
    if (txl[0] !== 1'b1 || busy[0] !== 1'b0) begin
      fails++;
      $display("FAIL rst_async: Tx=%b busy=%b expected 1 0", txl[0], busy[0]);
    end
    tx_data = 8'hFF;
    valid[0] = 1'b1;
    repeat (3) tick();
    valid[0] = 1'b0;
    nRst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (txl[0] !== 1'b1 || busy[0] !== 1'b0) begin
        fails++;
        $display("FAIL rst_no_accept: cycle %0d Tx=%b busy=%b expected 1 0", i, txl[0], busy[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_parity();
    test_two_stop();
    test_enable_drop();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
Serialises bytes onto a UART line at a fixed baud rate; sits directly upstream of the team's UART receiver and drives its Rx input.
- Frame: start bit, 8 data bits MSB-first (the bit order the receiver expects), optional parity, then STOP_BITS stop bits.
- A one-entry holding buffer lets the producer queue the next byte while the current frame shifts out, so consecutive frames follow with no idle gap.

Parameters:
BAUD_RATE, 9600, line bit rate
CLOCK_FREQ, 50000000, clk frequency in Hz
CYCLES_PER_BIT, CLOCK_FREQ/BAUD_RATE, clk cycles per line bit; must be >= 2 and < 65536
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, number of stop bits, 1 or 2

Ports:
clk  input  1  system clock, all logic on posedge
nRst  input  1  asynchronous active-low reset
enable  input  1  0 aborts activity and clears the buffer
tx_data  input  8  byte to send
tx_valid  input  1  producer offers tx_data
tx_ready  output  1  holding buffer empty and enable high; byte accepted on an edge where tx_valid and tx_ready are both 1
Tx  output  1  serial line, idle high, registered
busy  output  1  frame in progress (state != IDLE), registered

Behaviour:
Reset and enable:
- nRst low (async): Tx=1, busy=0, buffer empty, state IDLE, all counters 0. tx_ready=1 once enable is high.
- tx_ready = ~buf_full & enable (combinational from registers only; no dependency on tx_valid).

Holding buffer:
- On accept, tx_data is latched into buf and buf_full=1.
- buf is cleared only when its byte is loaded into the shifter.
- Accept and load on the same edge: the new byte is latched and buf_full stays 1.

State machine: IDLE, START, DATA, PARITY, STOP.
- baud_cnt is 16 bits and runs 0..CYCLES_PER_BIT-1 in every non-IDLE state.
- bit_end = (baud_cnt == CYCLES_PER_BIT-1); baud_cnt returns to 0 on bit_end.
- IDLE: if buf_full, load the shifter from buf, clear buf_full, compute the parity bit, go to START, Tx<=0, baud_cnt<=0. Otherwise Tx=1.
- START: Tx=0. On bit_end go to DATA with bit_idx=7 and Tx<=shifter[7].
- DATA: Tx=shifter[bit_idx]. On bit_end, decrement bit_idx. After bit 0, go to PARITY if PARITY!=0, else STOP.
- PARITY: Tx = even: XOR of the 8 data bits; odd: its inverse. On bit_end go to STOP.
- STOP: Tx=1 for STOP_BITS*CYCLES_PER_BIT cycles, tracked by stop_cnt. At the end of the last stop bit:
  - if buf_full, load directly and go to START (Tx<=0 on that edge, no IDLE cycle);
  - otherwise go to IDLE.

Timing:
- Byte accepted at edge k with the FSM in IDLE and buffer empty: buffer fills at k, Tx falls at edge k+1, busy rises at k+1.
- Each line bit lasts exactly CYCLES_PER_BIT cycles.
- Frame length = (1+8+(PARITY!=0)+STOP_BITS)*CYCLES_PER_BIT cycles.

Boundaries:
- enable low while active: on the next edge, state=IDLE, Tx=1, busy=0, buf_full=0. The partial frame is dropped; no resume.
- tx_valid held high while tx_ready=0: no accept; tx_data may change freely.
- Async reset mid-frame: Tx=1 immediately.

Test Plan:
1. Reset with CYCLES_PER_BIT=4, PARITY=0, STOP_BITS=1, enable=1, idle -> Tx=1, busy=0, tx_ready=1 for 20 cycles.
2. Accept 0xA5 -> Tx sampled at mid-bit (cycle 2 of each bit) reads 0,1,0,1,0,0,1,0,1,1. Tx falls 1 cycle after accept. busy high for exactly 40 cycles. tx_ready high again 1 cycle after accept.
3. Accept 0x3C then 0xC3 (second offered while the first is sending) -> 80 contiguous cycles. Second start bit begins the cycle after the first stop bit. tx_ready=0 from the second accept until the second byte loads.
4. PARITY=1, send 0xA5 -> parity bit 0. PARITY=2, send 0xA5 -> 1. PARITY=1, send 0x01 -> 1. Frame length 44 cycles.
5. STOP_BITS=2, send 0x00 -> 9 low bits then high for 8 cycles before the next start is allowed.
6. Drop enable at cycle 15 of a frame -> Tx=1, busy=0, buffer cleared next edge. Assert nRst low mid-frame -> Tx=1 immediately, no further accepts until nRst is high.
